// File: rtl/rng_share_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : rng_share_ctrl_if
//  Brief    : Seed / request / grant bundle between the RBM sampling units
//             and the shared random-word sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface rng_share_ctrl_if #(
    parameter int NREQ = 4,
    parameter int BITN = 16
);
    logic [BITN-1:0] seed;
    logic            seed_load;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [BITN-1:0] rnd_out;
    logic            rnd_valid;
    logic            ready;

    // Requester / seeding side
    modport master (
        output seed, seed_load, req,
        input  gnt, rnd_out, rnd_valid, ready
    );

    // Sequencer side
    modport slave (
        input  seed, seed_load, req,
        output gnt, rnd_out, rnd_valid, ready
    );
endinterface
`default_nettype wire

// File: rtl/rng_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rng_share_ctrl
//  Brief    : Shares one Fibonacci LFSR among NREQ stochastic-sampling units.
//             Seeds, discards WARMUP steps, then hands out one fresh word per
//             grant under round-robin arbitration.
//  Revision : 1.0 - initial release
// ============================================================================

// Fallback build configuration when the project config is not pulled in.
`ifndef BITN
`define BITN 16
`endif
`ifndef R_1
`define R_1 15
`endif
`ifndef R_2
`define R_2 13
`endif
`ifndef R_3
`define R_3 12
`endif
`ifndef R_4
`define R_4 10
`endif

module rng_share_ctrl #(
    parameter int NREQ   = 4,
    parameter int WARMUP = 16,
    parameter int BITN   = `BITN
) (
    input  logic                clk,
    input  logic                reset,
    rng_share_ctrl_if.slave     bus
);

    localparam int                  c_PTRW      = $clog2(NREQ);
    localparam logic [0:0]          c_WARM      = 1'b0;
    localparam logic [0:0]          c_SERVE     = 1'b1;
    localparam logic [7:0]          c_WARM_INIT = 8'(WARMUP - 1);
    localparam logic [c_PTRW-1:0]   c_LAST      = c_PTRW'(NREQ - 1);
    localparam logic [c_PTRW:0]     c_NREQ_EXT  = (c_PTRW + 1)'(NREQ);

    logic [BITN-1:0]    r_lfsr;
    logic [0:0]         r_state;
    logic [7:0]         r_warmCnt;
    logic [c_PTRW-1:0]  r_ptr;
    logic [NREQ-1:0]    r_gnt;
    logic [BITN-1:0]    r_rndOut;

    logic               w_fb;
    logic [BITN-1:0]    w_lfsrStep;
    logic               w_found;
    logic [c_PTRW-1:0]  w_k;
    logic [c_PTRW:0]    w_idx;

    logic [BITN-1:0]    w_lfsrNext;
    logic [0:0]         w_stateNext;
    logic [7:0]         w_warmCntNext;
    logic [c_PTRW-1:0]  w_ptrNext;
    logic [NREQ-1:0]    w_gntNext;
    logic [BITN-1:0]    w_rndOutNext;

    // The zero term lets the register escape the all-zero lock-up state.
    assign w_fb       = r_lfsr[`R_1] ^ r_lfsr[`R_2] ^ r_lfsr[`R_3] ^ r_lfsr[`R_4]
                      ^ (r_lfsr == '0);
    assign w_lfsrStep = {r_lfsr[BITN-2:0], w_fb};

    // Round-robin search: first set request at or after r_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_k     = '0;
        w_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = {1'b0, r_ptr} + (c_PTRW + 1)'(i);
            if (w_idx >= c_NREQ_EXT) begin
                w_idx = w_idx - c_NREQ_EXT;
            end
            if (!w_found && bus.req[w_idx[c_PTRW-1:0]]) begin
                w_found = 1'b1;
                w_k     = w_idx[c_PTRW-1:0];
            end
        end
    end

    // Next-state: reseed overrides everything, WARM steps and counts down,
    // SERVE steps only when a grant is issued.
    always_comb begin
        w_lfsrNext    = r_lfsr;
        w_stateNext   = r_state;
        w_warmCntNext = r_warmCnt;
        w_ptrNext     = r_ptr;
        w_gntNext     = '0;
        w_rndOutNext  = r_rndOut;
        if (bus.seed_load) begin
            w_lfsrNext    = bus.seed;
            w_warmCntNext = c_WARM_INIT;
            w_stateNext   = c_WARM;
        end else begin
            case (r_state)
                c_WARM: begin
                    w_lfsrNext = w_lfsrStep;
                    if (r_warmCnt == 8'd0) begin
                        w_stateNext = c_SERVE;
                    end else begin
                        w_warmCntNext = r_warmCnt - 8'd1;
                    end
                end
                c_SERVE: begin
                    if (w_found) begin
                        w_gntNext[w_k] = 1'b1;
                        w_rndOutNext   = r_lfsr;
                        w_lfsrNext     = w_lfsrStep;
                        w_ptrNext      = (w_k == c_LAST) ? '0 : w_k + 1'b1;
                    end
                end
                default: begin
                    w_stateNext = c_WARM;
                end
            endcase
        end
    end

    // State register; reset loads the seed and restarts warm-up asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr    <= bus.seed;
            r_state   <= c_WARM;
            r_warmCnt <= c_WARM_INIT;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_rndOut  <= '0;
        end else begin
            r_lfsr    <= w_lfsrNext;
            r_state   <= w_stateNext;
            r_warmCnt <= w_warmCntNext;
            r_ptr     <= w_ptrNext;
            r_gnt     <= w_gntNext;
            r_rndOut  <= w_rndOutNext;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rnd_out   = r_rndOut;
    assign bus.rnd_valid = |r_gnt;
    assign bus.ready     = (r_state == c_SERVE);

endmodule
`default_nettype wire

// File: tb/tb_rng_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rng_share_ctrl
//  Brief    : Directed self-checking bench for rng_share_ctrl (NREQ=4,
//             WARMUP=16, BITN=16, taps 15/13/12/10).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rng_share_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    rng_share_ctrl_if #(.NREQ(4), .BITN(16)) bus ();

    rng_share_ctrl #(
        .NREQ   (4),
        .WARMUP (16),
        .BITN   (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR step
    function automatic logic [15:0] stepf(input logic [15:0] x);
        logic fb;
        fb = x[15] ^ x[13] ^ x[12] ^ x[10] ^ (x == 16'h0000);
        return {x[14:0], fb};
    endfunction

    function automatic logic [15:0] stepn(input logic [15:0] x, input int n);
        logic [15:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = stepf(y);
        return y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready rises (bounded) and confirms no grant meanwhile.
    task automatic waitReady(input string tag, input int expEdges);
        int   n;
        logic sawGnt;
        n      = 0;
        sawGnt = 1'b0;
        while (!bus.ready && n < 100) begin
            tick;
            n++;
            if (bus.gnt !== 4'b0000) sawGnt = 1'b1;
        end
        chk({tag, "_edges"}, n, expEdges);
        chk({tag, "_nognt"}, {31'b0, sawGnt}, 32'd0);
    endtask

    logic [3:0]  expG [5];
    logic [15:0] m;
    logic [15:0] held;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        expG   = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        reset         = 1'b1;
        bus.seed      = 16'h0001;
        bus.seed_load = 1'b0;
        bus.req       = 4'h0;

        // Reset state
        tick; tick;
        chk("rst_gnt",   {28'b0, bus.gnt},   32'd0);
        chk("rst_rnd",   {16'b0, bus.rnd_out}, 32'd0);
        chk("rst_valid", {31'b0, bus.rnd_valid}, 32'd0);
        chk("rst_ready", {31'b0, bus.ready}, 32'd0);

        // Warm-up from seed 1: exactly 16 edges
        reset = 1'b0;
        waitReady("warm1", 16);

        // All requesters active: 0,1,2,3,0 with consecutive LFSR states
        m = 16'h002D;
        bus.req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("rr_gnt",   {28'b0, bus.gnt}, {28'b0, expG[i]});
            chk("rr_rnd",   {16'b0, bus.rnd_out}, {16'b0, m});
            chk("rr_valid", {31'b0, bus.rnd_valid}, 32'd1);
            if (i == 1) chk("rr_second_word", {16'b0, bus.rnd_out}, 32'h005A);
            m = stepf(m);
        end

        // Only req[2]: ptr was 1, grant 2, ptr becomes 3
        bus.req = 4'b0100;
        tick;
        chk("r2_gnt", {28'b0, bus.gnt}, 32'h4);
        chk("r2_rnd", {16'b0, bus.rnd_out}, {16'b0, m});
        held = m;
        m = stepf(m);
        bus.req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("idle_gnt",   {28'b0, bus.gnt}, 32'd0);
            chk("idle_valid", {31'b0, bus.rnd_valid}, 32'd0);
            chk("idle_rnd",   {16'b0, bus.rnd_out}, {16'b0, held});
        end
        bus.req = 4'b0100;
        tick;
        chk("r2b_gnt", {28'b0, bus.gnt}, 32'h4);
        chk("r2b_rnd", {16'b0, bus.rnd_out}, {16'b0, m});
        m = stepf(m);
        // ptr is 3: requester 3 beats requester 2
        bus.req = 4'b1100;
        tick;
        chk("ptr3_gnt", {28'b0, bus.gnt}, 32'h8);
        chk("ptr3_rnd", {16'b0, bus.rnd_out}, {16'b0, m});

        // Reseed with zero while req[1] pending
        bus.req       = 4'b0010;
        bus.seed      = 16'h0000;
        bus.seed_load = 1'b1;
        tick;
        chk("sl0_gnt",   {28'b0, bus.gnt}, 32'd0);
        chk("sl0_ready", {31'b0, bus.ready}, 32'd0);
        bus.seed_load = 1'b0;
        waitReady("warm0", 16);
        tick;
        chk("sl0_gnt1", {28'b0, bus.gnt}, 32'h2);
        chk("sl0_rnd",  {16'b0, bus.rnd_out}, 32'h8016);
        m = stepf(16'h8016);

        // ptr=2, only req[0]: grant 0; reseed during that grant cycle
        bus.req = 4'b0001;
        tick;
        chk("inf_gnt", {28'b0, bus.gnt}, 32'h1);
        chk("inf_rnd", {16'b0, bus.rnd_out}, {16'b0, m});
        bus.seed      = 16'hACE1;
        bus.seed_load = 1'b1;
        #2;
        chk("inf_hold_gnt", {28'b0, bus.gnt}, 32'h1);
        tick;
        chk("inf_clr_gnt",   {28'b0, bus.gnt}, 32'd0);
        chk("inf_clr_ready", {31'b0, bus.ready}, 32'd0);
        bus.seed_load = 1'b0;

        // Two reloads of the same seed produce identical sequences
        for (int pass = 0; pass < 2; pass++) begin
            waitReady("warmA", 16);
            m = stepn(16'hACE1, 16);
            for (int i = 0; i < 3; i++) begin
                tick;
                chk("seq_gnt", {28'b0, bus.gnt}, 32'h1);
                chk("seq_rnd", {16'b0, bus.rnd_out}, {16'b0, m});
                m = stepf(m);
            end
            if (pass == 0) begin
                bus.seed_load = 1'b1;
                tick;
                chk("rel_gnt", {28'b0, bus.gnt}, 32'd0);
                bus.seed_load = 1'b0;
            end
        end

        // Async reset mid-grant
        bus.req = 4'hF;
        tick; tick;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_gnt",   {28'b0, bus.gnt}, 32'd0);
        chk("ar_valid", {31'b0, bus.rnd_valid}, 32'd0);
        chk("ar_ready", {31'b0, bus.ready}, 32'd0);
        chk("ar_rnd",   {16'b0, bus.rnd_out}, 32'd0);
        bus.seed = 16'h0001;
        @(posedge clk);
        #1;
        reset = 1'b0;
        waitReady("warmR", 16);
        tick;
        chk("ar_restart_gnt", {28'b0, bus.gnt}, 32'h1);
        chk("ar_restart_rnd", {16'b0, bus.rnd_out}, 32'h002D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
